// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 registered multiplexer.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Bit offset of channel idx inside a flat N*W bus.
  function automatic int chan_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority search: the first requester after ptr wins, wrapping mod N.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    // Walk from farthest to nearest so the closest requester overwrites last.
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt_vld = 1'b1;
        gnt_idx = SEL_W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/mux_nx1_rr.sv
// N:1 mux with fixed or round-robin channel choice and a one-entry registered output.
module mux_nx1_rr
  import mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_chan,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_idx, grant;
  logic             rr_vld, fix_vld, grant_vld;
  logic             load_en;

  rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  assign load_en = !out_valid || out_ready;
  assign fix_vld = (int'(sel) < N) ? in_valid[sel] : 1'b0;

  always_comb begin
    grant     = sel;
    grant_vld = fix_vld;
    if (mode == MODE_RR) begin
      grant     = rr_idx;
      grant_vld = rr_vld;
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++)
      in_ready[i] = !rst && load_en && grant_vld && (int'(grant) == i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= SEL_W'(N - 1);
    end else if (load_en) begin
      if (grant_vld) begin
        out_valid <= 1'b1;
        out_data  <= in_data[chan_lsb(int'(grant), W) +: W];
        out_chan  <= grant;
        // Only RR transfers move the pointer; fixed-mode traffic leaves it alone.
        if (mode == MODE_RR) rr_ptr <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed bench for mux_nx1_rr (N=4, W=8): reset, fixed, RR fairness, backpressure, wrap, mode switch.
module tb_mux_nx1_rr;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic         mode;
  logic [1:0]   sel;
  logic [W-1:0] out_data;
  logic [1:0]   out_chan;
  logic         out_valid;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  mux_nx1_rr #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pre-edge: one-hot ready for ch; post-edge: output carries ch with its data.
  task automatic xfer(input string tag, input int ch, input logic [7:0] d);
    chk({tag, "_rdy"}, 32'(in_ready), 32'(1 << ch));
    step();
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_chan"}, 32'(out_chan), 32'(ch));
    chk({tag, "_data"}, 32'(out_data), 32'(d));
  endtask

  task automatic default_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'h10 + 8'(i);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
    in_valid = 4'b1111;
    default_data();

    // Reset held two cycles with every channel offering
    step(); step();
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_chan", 32'(out_chan), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);

    // Fixed select
    rst = 1'b0; mode = 1'b0; sel = 2'd2;
    in_data[2*W +: W] = 8'hA5;
    in_valid = 4'b0100;
    #1;
    xfer("fix2", 2, 8'hA5);
    sel = 2'd3;
    #1;
    chk("fix3_rdy", 32'(in_ready), 32'd0);
    step();
    chk("fix3_vld", 32'(out_valid), 32'd0);

    // Round-robin fairness; rr_ptr still at reset value so ch0 first
    default_data();
    mode = 1'b1; in_valid = 4'b1111;
    #1;
    xfer("rr0", 0, 8'h10);
    xfer("rr1", 1, 8'h11);
    xfer("rr2", 2, 8'h12);
    xfer("rr3", 3, 8'h13);
    xfer("rr4", 0, 8'h10);

    // Backpressure holds output and blocks inputs
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_rdy", 32'(in_ready), 32'd0);
      step();
      chk("bp_vld", 32'(out_valid), 32'd1);
      chk("bp_chan", 32'(out_chan), 32'd0);
      chk("bp_data", 32'(out_data), 32'h10);
    end
    out_ready = 1'b1;
    #1;
    xfer("bp_rel", 1, 8'h11);

    // Sparse requests wrapping through the pointer
    xfer("sp2", 2, 8'h12);
    xfer("sp3", 3, 8'h13);
    in_valid = 4'b1001;
    #1;
    xfer("wrap0", 0, 8'h10);
    xfer("wrap3", 3, 8'h13);
    xfer("wrap0b", 0, 8'h10);

    // Mode switch: fixed sel=1 does not move rr_ptr (still 0)
    in_valid = 4'b1111; mode = 1'b0; sel = 2'd1;
    #1;
    xfer("msw_fix", 1, 8'h11);
    mode = 1'b1;
    #1;
    xfer("msw_rr", 1, 8'h11);

    // Reset while holding a word
    rst = 1'b1;
    #1;
    chk("mrst_rdy", 32'(in_ready), 32'd0);
    step();
    chk("mrst_vld", 32'(out_valid), 32'd0);
    chk("mrst_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    #1;
    xfer("restart", 0, 8'h10);
    xfer("restart2", 1, 8'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
